// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write-back port and a per-register pending scoreboard.
// Optional write-through forwarding and hazard masking are enabled with `define RF_BYPASS_EN.
module regfile_scoreboard #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [ADDR_W-1:0]   rd0_addr,
    input  logic                rd0_used,
    output logic [DATA_W-1:0]   rd0_data,
    input  logic [ADDR_W-1:0]   rd1_addr,
    input  logic                rd1_used,
    output logic [DATA_W-1:0]   rd1_data,
    input  logic                issue_en,
    input  logic [ADDR_W-1:0]   issue_addr,
    output logic                hazard,
    output logic [NUM_REGS-1:0] pending
);

    localparam logic [NUM_REGS-1:0] ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic [NUM_REGS-1:0] pend_eff;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_en && !hazard) begin
            set_vec = ONE << issue_addr;
        end
        if (wr_en) begin
            clr_vec = ONE << wr_addr;
        end
    end

    // Set is applied after clear: a new reservation outranks the retiring write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_vec) | set_vec;
        end
    end

`ifdef RF_BYPASS_EN
    always_comb begin
        pend_eff = pending & ~clr_vec;
        rd0_data = (wr_en && (rd0_addr == wr_addr)) ? wr_data : regs[rd0_addr];
        rd1_data = (wr_en && (rd1_addr == wr_addr)) ? wr_data : regs[rd1_addr];
    end
`else
    always_comb begin
        pend_eff = pending;
        rd0_data = regs[rd0_addr];
        rd1_data = regs[rd1_addr];
    end
`endif

    assign hazard = (rd0_used & pend_eff[rd0_addr]) | (rd1_used & pend_eff[rd1_addr]);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (default 8x8 configuration).
module tb_regfile_scoreboard;

    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 3;

    logic                clock = 1'b0;
    logic                reset;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [ADDR_W-1:0]   rd0_addr;
    logic                rd0_used;
    logic [DATA_W-1:0]   rd0_data;
    logic [ADDR_W-1:0]   rd1_addr;
    logic                rd1_used;
    logic [DATA_W-1:0]   rd1_data;
    logic                issue_en;
    logic [ADDR_W-1:0]   issue_addr;
    logic                hazard;
    logic [NUM_REGS-1:0] pending;

    int n_checks = 0;
    int n_fails  = 0;

    regfile_scoreboard #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
        .clock(clock), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd0_addr(rd0_addr), .rd0_used(rd0_used), .rd0_data(rd0_data),
        .rd1_addr(rd1_addr), .rd1_used(rd1_used), .rd1_data(rd1_data),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .hazard(hazard), .pending(pending)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0; wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5;
        rd0_addr = 3'd3; rd0_used = 1'b0; rd1_addr = 3'd0; rd1_used = 1'b0;
        issue_en = 1'b1; issue_addr = 3'd1;
        tick(); tick();
        chk("rst_hold_rd0", rd0_data, 8'h00);
        chk("rst_hold_pend", pending, 8'h00);
        wr_en = 1'b0; issue_en = 1'b0;
        #2 reset = 1'b1;
        tick();
        chk("rst_rd0", rd0_data, 8'h00);
        chk("rst_rd1", rd1_data, 8'h00);
        chk("rst_pend", pending, 8'h00);
        chk("rst_hazard", hazard, 1'b0);

        // basic write / read
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h3C;
        tick();
        wr_addr = 3'd7; wr_data = 8'hF0; rd0_addr = 3'd2;
        #1 chk("rd0_reg2", rd0_data, 8'h3C);
        tick();
        wr_en = 1'b0; rd1_addr = 3'd7;
        #1 chk("rd1_reg7", rd1_data, 8'hF0);
        rd0_addr = 3'd7;
        #1 chk("dual_rd0_reg7", rd0_data, 8'hF0);
        chk("dual_rd1_reg7", rd1_data, 8'hF0);
        chk("wr_nonpend_pend", pending, 8'h00);

        // scoreboard stall
        issue_en = 1'b1; issue_addr = 3'd5;
        tick();
        issue_en = 1'b0; rd1_addr = 3'd5; rd1_used = 1'b1;
        #1 chk("stall_pend", pending, 8'h20);
        chk("stall_hazard", hazard, 1'b1);
        rd1_used = 1'b0;
        #1 chk("unused_hazard", hazard, 1'b0);
        rd0_addr = 3'd5; rd0_used = 1'b1;
        #1 chk("rd0_used_hazard", hazard, 1'b1);
        rd0_used = 1'b0; rd0_addr = 3'd2; rd1_used = 1'b1;
        issue_en = 1'b1; issue_addr = 3'd6;
        tick();
        issue_en = 1'b0;
        chk("ignored_issue_pend", pending, 8'h20);

        // write-back release
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h77;
        #1;
`ifdef RF_BYPASS_EN
        chk("wb_same_hazard", hazard, 1'b0);
        chk("wb_same_rd1", rd1_data, 8'h77);
`else
        chk("wb_same_hazard", hazard, 1'b1);
        chk("wb_same_rd1", rd1_data, 8'h00);
`endif
        tick();
        wr_en = 1'b0;
        #1 chk("wb_next_hazard", hazard, 1'b0);
        chk("wb_next_rd1", rd1_data, 8'h77);
        chk("wb_next_pend", pending, 8'h00);
        rd1_used = 1'b0;

        // simultaneous set and clear on reg 4
        issue_en = 1'b1; issue_addr = 3'd4;
        tick();
        chk("sc_pre_pend", pending, 8'h10);
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h5A;
        tick();
        wr_en = 1'b0; issue_en = 1'b0; rd0_addr = 3'd4;
        #1 chk("sc_pend", pending, 8'h10);
        chk("sc_rd0", rd0_data, 8'h5A);

        // fill the scoreboard, including the top address
        issue_en = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) begin
            issue_addr = ADDR_W'(i);
            tick();
        end
        issue_en = 1'b0;
        chk("fill_pend", pending, 8'hFF);
        rd0_addr = 3'd2; rd1_addr = 3'd7; rd0_used = 1'b1;
        #1 chk("fill_hazard", hazard, 1'b1);
        chk("fill_rd1", rd1_data, 8'hF0);

        // asynchronous reset between edges
        #2 reset = 1'b0;
        #1 chk("async_rd0", rd0_data, 8'h00);
        chk("async_rd1", rd1_data, 8'h00);
        chk("async_pend", pending, 8'h00);
        chk("async_hazard", hazard, 1'b0);
        reset = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised general-purpose register file for the pipelined datapath; next generation of the 8x8 single-port register bank.
- Two asynchronous read ports (ALU operands A/B), one synchronous write-back port.
- Per-register pending scoreboard: decode marks destinations busy, write-back clears them; the block raises a hazard stall to decode.

Parameters:
- DATA_W, 8, register width in bits.
- NUM_REGS, 8, number of registers; must be a power of two, at least 2.
- ADDR_W, $clog2(NUM_REGS), register address width; derived, do not override.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  write-back strobe.
- wr_addr  in  ADDR_W  write-back destination.
- wr_data  in  DATA_W  write-back value.
- rd0_addr  in  ADDR_W  operand A select.
- rd0_used  in  1  operand A is consumed by the instruction in decode.
- rd0_data  out  DATA_W  operand A value.
- rd1_addr  in  ADDR_W  operand B select.
- rd1_used  in  1  operand B is consumed.
- rd1_data  out  DATA_W  operand B value.
- issue_en  in  1  decode issues an instruction that writes issue_addr.
- issue_addr  in  ADDR_W  destination being reserved.
- hazard  out  1  decode must stall this cycle.
- pending  out  NUM_REGS  scoreboard bit vector; bit i set means register i is awaiting write-back.

Behaviour:
- Reset (reset=0, asynchronous): all registers are 0 and pending is 0, so hazard=0 and rd*_data=0. Reset has effect immediately and mid-operation; any in-flight write is discarded.
- Write: on the rising edge with wr_en=1, regs[wr_addr] <= wr_data. Write latency is 1 cycle.
- Read: rd0_data and rd1_data are combinational reads of regs[rd*_addr] (see RF_BYPASS_EN). Both ports may address the same register.
- Scoreboard, per edge and for each i:
  - Set when issue_en=1, hazard=0, and issue_addr=i.
  - Cleared when wr_en=1 and wr_addr=i.
  - If set and clear hit the same i in the same cycle, set wins: the new reservation is newer than the retiring write. pending[i] stays 1.
  - issue_en while hazard=1 is ignored and does not reserve.
  - Issuing to an already-pending register is legal; the bit stays 1. The single bit does not count outstanding writes, and the pipeline guarantees in-order write-back.
- Hazard (combinational): hazard = (rd0_used & pend_eff[rd0_addr]) | (rd1_used & pend_eff[rd1_addr]).
  - pend_eff is pending with the bit for wr_addr masked off when wr_en=1 and RF_BYPASS_EN is defined.
  - Without the feature, pend_eff equals pending.
- Boundaries:
  - Address NUM_REGS-1 is valid.
  - No wrap: addresses are exactly ADDR_W bits wide.
  - A write to a non-pending register is legal; the data is stored and pending is unchanged.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: write-through forwarding.
  - When wr_en=1 and rd*_addr=wr_addr, rd*_data=wr_data in the same cycle.
  - The retiring register is masked out of hazard, so a dependent instruction proceeds one cycle earlier.
- Undefined:
  - Reads return the stored value only.
  - A dependent instruction stalls until the cycle after write-back.
  - Both paths are removed from the logic.

Test Plan:
- Reset check: hold reset=0 while driving wr_en=1, wr_addr=3, wr_data=8'hA5 -> after release, all reads return 8'h00, pending=8'h00, hazard=0.
- Basic write/read: write 8'h3C to reg 2, then 8'hF0 to reg 7 -> rd0_addr=2 gives 8'h3C; rd1_addr=7 gives 8'hF0 on the next cycle; rd0=rd1=7 gives 8'hF0 on both ports.
- Scoreboard stall: issue_en with issue_addr=5, next cycle rd1_addr=5, rd1_used=1 -> hazard=1, pending=8'h20.
  - With rd1_used=0 -> hazard=0.
  - A further issue_en while hazard=1 leaves pending unchanged.
- Write-back release: after the stall above, wr_en=1, wr_addr=5, wr_data=8'h77.
  - With RF_BYPASS_EN: same cycle hazard=0 and rd1_data=8'h77.
  - Without it: hazard=1 that cycle, then hazard=0 and rd1_data=8'h77 the next cycle.
  - pending=8'h00 afterwards in both builds.
- Simultaneous set/clear: pending[4]=1, same edge wr_en at wr_addr=4 and issue_en at issue_addr=4 (hazard=0) -> pending[4] stays 1 and regs[4] is updated.
- Asynchronous mid-run reset: pending=8'hFF, regs non-zero, assert reset between edges -> outputs go to 0 before the next edge.
